// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU character framebuffer write path:
// register map, command codes, controller states and text-grid defaults.
package gpu_pkg;

    localparam int unsigned COLS_DEF = 100;
    localparam int unsigned ROWS_DEF = 75;

    localparam logic [1:0] REG_CHAR = 2'd0;
    localparam logic [1:0] REG_COL  = 2'd1;
    localparam logic [1:0] REG_ROW  = 2'd2;
    localparam logic [1:0] REG_CMD  = 2'd3;

    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_NEWLINE = 8'h02;
    localparam logic [7:0] CMD_HOME    = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_REL
    } state_t;

endpackage

// File: rtl/gpu_cursor.sv
// Text cursor: column/row counters with advance, newline, home and
// saturating loads; exports the linear cell address row*COLS+col.
module gpu_cursor
    import gpu_pkg::*;
#(
    parameter int unsigned COLS  = COLS_DEF,
    parameter int unsigned ROWS  = ROWS_DEF,
    parameter int unsigned FB_AW = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             newline,
    input  logic             home,
    input  logic             load_col,
    input  logic             load_row,
    input  logic [7:0]       load_data,
    output logic [6:0]       col,
    output logic [6:0]       row,
    output logic [FB_AW-1:0] addr
);

    localparam logic [6:0] COL_MAX = 7'(COLS - 1);
    localparam logic [6:0] ROW_MAX = 7'(ROWS - 1);

    logic [6:0] col_q, col_d;
    logic [6:0] row_q, row_d;
    logic [6:0] row_inc;

    always_comb begin
        row_inc = (row_q == ROW_MAX) ? '0 : row_q + 7'd1;
        col_d   = col_q;
        row_d   = row_q;
        if (home) begin
            col_d = '0;
            row_d = '0;
        end else if (advance) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = row_inc;
            end else begin
                col_d = col_q + 7'd1;
            end
        end else if (newline) begin
            col_d = '0;
            row_d = row_inc;
        end else if (load_col) begin
            col_d = (load_data > {1'b0, COL_MAX}) ? COL_MAX : load_data[6:0];
        end else if (load_row) begin
            row_d = (load_data > {1'b0, ROW_MAX}) ? ROW_MAX : load_data[6:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign addr = FB_AW'(row_q) * FB_AW'(COLS) + FB_AW'(col_q);

endmodule

// File: rtl/gpu_fb_write_ctrl.sv
// CPU-side framebuffer write sequencer: register decode, request handshake,
// cursor control and the clear-screen sweep, all outputs registered.
module gpu_fb_write_ctrl
    import gpu_pkg::*;
#(
    parameter int unsigned COLS       = COLS_DEF,
    parameter int unsigned ROWS       = ROWS_DEF,
    parameter int unsigned FB_AW      = 13,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input  logic             CLK_PIXEL,
    input  logic             RST,
    input  logic             WR_REQ,
    input  logic [1:0]       WR_ADDR,
    input  logic [7:0]       WR_DATA,
    output logic             WR_ACK,
    output logic             BUSY,
    output logic             FB_WE,
    output logic [FB_AW-1:0] FB_ADDR,
    output logic [7:0]       FB_DATA,
    output logic [6:0]       CURSOR_COL,
    output logic [6:0]       CURSOR_ROW
);

    localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(COLS * ROWS - 1);

    state_t           state_q, state_d;
    logic             wr_ack_q, wr_ack_d;
    logic             busy_q, busy_d;
    logic             fb_we_q, fb_we_d;
    logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]       fb_data_q, fb_data_d;
    logic [FB_AW-1:0] clr_cnt_q, clr_cnt_d;
    logic             rel_seen_q, rel_seen_d;
    logic [FB_AW-1:0] clr_cnt_inc;

    logic             cur_advance, cur_newline, cur_home, cur_load_col, cur_load_row;
    logic [FB_AW-1:0] cur_addr;

    gpu_cursor #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .FB_AW (FB_AW)
    ) u_cursor (
        .clk       (CLK_PIXEL),
        .rst       (RST),
        .advance   (cur_advance),
        .newline   (cur_newline),
        .home      (cur_home),
        .load_col  (cur_load_col),
        .load_row  (cur_load_row),
        .load_data (WR_DATA),
        .col       (CURSOR_COL),
        .row       (CURSOR_ROW),
        .addr      (cur_addr)
    );

    always_comb begin
        state_d      = state_q;
        wr_ack_d     = 1'b0;
        busy_d       = 1'b0;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        clr_cnt_d    = clr_cnt_q;
        rel_seen_d   = rel_seen_q;
        clr_cnt_inc  = clr_cnt_q + 1'b1;
        cur_advance  = 1'b0;
        cur_newline  = 1'b0;
        cur_home     = 1'b0;
        cur_load_col = 1'b0;
        cur_load_row = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (WR_REQ) begin
                    wr_ack_d = 1'b1;
                    state_d  = ST_WAIT_REL;
                    case (WR_ADDR)
                        REG_CHAR: begin
                            fb_we_d     = 1'b1;
                            fb_addr_d   = cur_addr;
                            fb_data_d   = WR_DATA;
                            cur_advance = 1'b1;
                        end
                        REG_COL: cur_load_col = 1'b1;
                        REG_ROW: cur_load_row = 1'b1;
                        default: begin
                            case (WR_DATA)
                                CMD_CLEAR: begin
                                    state_d    = ST_CLEAR;
                                    busy_d     = 1'b1;
                                    fb_we_d    = 1'b1;
                                    fb_addr_d  = '0;
                                    fb_data_d  = CLEAR_CHAR;
                                    clr_cnt_d  = '0;
                                    rel_seen_d = 1'b0;
                                end
                                CMD_NEWLINE: cur_newline = 1'b1;
                                CMD_HOME:    cur_home = 1'b1;
                                default: ;
                            endcase
                        end
                    endcase
                end
            end
            ST_CLEAR: begin
                // Once the originating request has dropped, any later WR_REQ is a
                // new one waiting for its ack, so the sweep must exit straight to IDLE.
                if (!WR_REQ) rel_seen_d = 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = (rel_seen_q || !WR_REQ) ? ST_IDLE : ST_WAIT_REL;
                end else begin
                    busy_d    = 1'b1;
                    fb_we_d   = 1'b1;
                    fb_addr_d = clr_cnt_inc;
                    fb_data_d = CLEAR_CHAR;
                    clr_cnt_d = clr_cnt_inc;
                    cur_home  = (clr_cnt_inc == LAST_ADDR);
                end
            end
            ST_WAIT_REL: begin
                if (!WR_REQ) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_PIXEL or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            wr_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            clr_cnt_q  <= '0;
            rel_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ack_q   <= wr_ack_d;
            busy_q     <= busy_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            clr_cnt_q  <= clr_cnt_d;
            rel_seen_q <= rel_seen_d;
        end
    end

    assign WR_ACK  = wr_ack_q;
    assign BUSY    = busy_q;
    assign FB_WE   = fb_we_q;
    assign FB_ADDR = fb_addr_q;
    assign FB_DATA = fb_data_q;

endmodule

// File: tb/tb_gpu_fb_write_ctrl.sv
// Directed self-checking bench for gpu_fb_write_ctrl with the default
// 100x75 grid; expected values are hand-computed per scenario.
module tb_gpu_fb_write_ctrl;

    logic        clk;
    logic        rst;
    logic        wr_req;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        busy;
    logic        fb_we;
    logic [12:0] fb_addr;
    logic [7:0]  fb_data;
    logic [6:0]  cursor_col;
    logic [6:0]  cursor_row;

    int checks = 0;
    int passed = 0;

    gpu_fb_write_ctrl #(
        .COLS       (100),
        .ROWS       (75),
        .FB_AW      (13),
        .CLEAR_CHAR (8'h20)
    ) dut (
        .CLK_PIXEL  (clk),
        .RST        (rst),
        .WR_REQ     (wr_req),
        .WR_ADDR    (wr_addr),
        .WR_DATA    (wr_data),
        .WR_ACK     (wr_ack),
        .BUSY       (busy),
        .FB_WE      (fb_we),
        .FB_ADDR    (fb_addr),
        .FB_DATA    (fb_data),
        .CURSOR_COL (cursor_col),
        .CURSOR_ROW (cursor_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one register write, holds it for at least `hold` sampled edges and
    // until acked (bounded), then releases and watches three more cycles.
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input int hold,
                             output int acks, output int wes,
                             output logic [12:0] waddr, output logic [7:0] wdata);
        acks  = 0;
        wes   = 0;
        waddr = '1;
        wdata = '0;
        @(negedge clk);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (wr_ack) acks++;
            if (fb_we) begin wes++; waddr = fb_addr; wdata = fb_data; end
            if (acks > 0 && i + 1 >= hold) break;
        end
        @(negedge clk);
        wr_req = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (wr_ack) acks++;
            if (fb_we) begin wes++; waddr = fb_addr; wdata = fb_data; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wr_ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", wr_ack); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (fb_we !== 1'b0) $display("FAIL reset_we got=%b exp=0", fb_we); else passed++;
        checks++; if (fb_addr !== 13'd0 || fb_data !== 8'h00)
            $display("FAIL reset_fb got=%0d/%h exp=0/00", fb_addr, fb_data); else passed++;
        checks++; if (cursor_col !== 7'd0 || cursor_row !== 7'd0)
            $display("FAIL reset_cursor got=(%0d,%0d) exp=(0,0)", cursor_col, cursor_row); else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_char();
        int acks, wes; logic [12:0] wa; logic [7:0] wd;
        bus_write(2'd0, 8'h41, 1, acks, wes, wa, wd);
        checks++; if (acks !== 1) $display("FAIL char_ack got=%0d exp=1", acks); else passed++;
        checks++; if (wes !== 1) $display("FAIL char_we got=%0d exp=1", wes); else passed++;
        checks++; if (wa !== 13'd0 || wd !== 8'h41)
            $display("FAIL char_write got=%0d/%h exp=0/41", wa, wd); else passed++;
        checks++; if (cursor_col !== 7'd1 || cursor_row !== 7'd0)
            $display("FAIL char_cursor got=(%0d,%0d) exp=(1,0)", cursor_col, cursor_row); else passed++;
    endtask

    task automatic test_cursor_regs();
        int acks, wes; logic [12:0] wa; logic [7:0] wd;
        bus_write(2'd1, 8'd3, 1, acks, wes, wa, wd);
        bus_write(2'd2, 8'd2, 1, acks, wes, wa, wd);
        bus_write(2'd0, 8'h5A, 1, acks, wes, wa, wd);
        checks++; if (wa !== 13'd203 || wd !== 8'h5A)
            $display("FAIL mid_addr got=%0d/%h exp=203/5a", wa, wd); else passed++;
        bus_write(2'd1, 8'd99, 1, acks, wes, wa, wd);
        bus_write(2'd2, 8'd74, 1, acks, wes, wa, wd);
        bus_write(2'd0, 8'h42, 1, acks, wes, wa, wd);
        checks++; if (wa !== 13'd7499 || wd !== 8'h42 || wes !== 1)
            $display("FAIL last_cell got=%0d/%h/%0d exp=7499/42/1", wa, wd, wes); else passed++;
        checks++; if (cursor_col !== 7'd0 || cursor_row !== 7'd0)
            $display("FAIL wrap_cursor got=(%0d,%0d) exp=(0,0)", cursor_col, cursor_row); else passed++;
        bus_write(2'd1, 8'd200, 1, acks, wes, wa, wd);
        bus_write(2'd2, 8'd90, 1, acks, wes, wa, wd);
        checks++; if (cursor_col !== 7'd99 || cursor_row !== 7'd74)
            $display("FAIL saturate got=(%0d,%0d) exp=(99,74)", cursor_col, cursor_row); else passed++;
        bus_write(2'd3, 8'h02, 1, acks, wes, wa, wd);
        checks++; if (cursor_col !== 7'd0 || cursor_row !== 7'd0 || wes !== 0)
            $display("FAIL newline_wrap got=(%0d,%0d) we=%0d exp=(0,0) we=0", cursor_col, cursor_row, wes); else passed++;
        bus_write(2'd3, 8'h02, 1, acks, wes, wa, wd);
        checks++; if (cursor_col !== 7'd0 || cursor_row !== 7'd1)
            $display("FAIL newline got=(%0d,%0d) exp=(0,1)", cursor_col, cursor_row); else passed++;
        bus_write(2'd1, 8'd5, 1, acks, wes, wa, wd);
        bus_write(2'd3, 8'h03, 1, acks, wes, wa, wd);
        checks++; if (cursor_col !== 7'd0 || cursor_row !== 7'd0)
            $display("FAIL home got=(%0d,%0d) exp=(0,0)", cursor_col, cursor_row); else passed++;
        bus_write(2'd3, 8'h7F, 1, acks, wes, wa, wd);
        checks++; if (acks !== 1 || wes !== 0 || busy !== 1'b0)
            $display("FAIL unknown_cmd got=ack%0d we%0d busy%b exp=ack1 we0 busy0", acks, wes, busy); else passed++;
    endtask

    task automatic test_clear();
        int acks, wes; logic [12:0] wa; logic [7:0] wd;
        int busy_cycles = 0, bad = 0, acks_during = 0, ack_wait = 0;
        logic ack_first = 1'b0, ended = 1'b0, got_ack = 1'b0;
        logic [12:0] exp_addr = '0;
        logic [6:0] last_col = '1, last_row = '1;
        bus_write(2'd1, 8'd5, 1, acks, wes, wa, wd);
        bus_write(2'd2, 8'd5, 1, acks, wes, wa, wd);
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 2'd3; wr_data = 8'h01;
        for (int i = 0; i < 8000; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin ack_first = wr_ack; wr_req = 1'b0; end
            if (!busy) begin ended = 1'b1; break; end
            busy_cycles++;
            if (fb_we !== 1'b1 || fb_addr !== exp_addr || fb_data !== 8'h20) bad++;
            exp_addr++;
            if (i > 0 && wr_ack) acks_during++;
            if (fb_addr == 13'd7499) begin last_col = cursor_col; last_row = cursor_row; end
            if (i == 100) begin wr_req = 1'b1; wr_addr = 2'd0; wr_data = 8'h55; end
        end
        checks++; if (ack_first !== 1'b1) $display("FAIL clear_ack got=%b exp=1", ack_first); else passed++;
        checks++; if (!ended || busy_cycles !== 7500)
            $display("FAIL clear_len got=%0d exp=7500", busy_cycles); else passed++;
        checks++; if (bad !== 0) $display("FAIL clear_sweep got=%0d bad cycles exp=0", bad); else passed++;
        checks++; if (acks_during !== 0) $display("FAIL clear_ack_mid got=%0d exp=0", acks_during); else passed++;
        checks++; if (fb_we !== 1'b0 || wr_ack !== 1'b0)
            $display("FAIL clear_end got=we%b ack%b exp=we0 ack0", fb_we, wr_ack); else passed++;
        checks++; if (last_col !== 7'd0 || last_row !== 7'd0)
            $display("FAIL clear_cursor got=(%0d,%0d) exp=(0,0)", last_col, last_row); else passed++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            ack_wait++;
            if (wr_ack) begin got_ack = 1'b1; wa = fb_addr; wd = fb_data; break; end
        end
        checks++; if (!got_ack || ack_wait !== 1 || wa !== 13'd0 || wd !== 8'h55)
            $display("FAIL pending_req got=ack%b wait%0d %0d/%h exp=ack1 wait1 0/55", got_ack, ack_wait, wa, wd); else passed++;
        @(negedge clk);
        wr_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int acks, wes; logic [12:0] wa; logic [7:0] wd;
        bus_write(2'd0, 8'h66, 10, acks, wes, wa, wd);
        checks++; if (acks !== 1 || wes !== 1)
            $display("FAIL held_req got=ack%0d we%0d exp=ack1 we1", acks, wes); else passed++;
        checks++; if (wa !== 13'd1 || cursor_col !== 7'd2 || cursor_row !== 7'd0)
            $display("FAIL held_cursor got=%0d (%0d,%0d) exp=1 (2,0)", wa, cursor_col, cursor_row); else passed++;
    endtask

    task automatic test_reset_mid_sweep();
        int acks, wes; logic [12:0] wa; logic [7:0] wd;
        int cnt = 0;
        bus_write(2'd1, 8'd10, 1, acks, wes, wa, wd);
        bus_write(2'd2, 8'd10, 1, acks, wes, wa, wd);
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 2'd3; wr_data = 8'h01;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            if (i == 0) wr_req = 1'b0;
            if (busy) cnt++;
            if (cnt == 3000) break;
        end
        checks++; if (cnt !== 3000 || busy !== 1'b1 || fb_addr !== 13'd2999)
            $display("FAIL sweep_3000 got=%0d busy%b addr%0d exp=3000 busy1 addr2999", cnt, busy, fb_addr); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (fb_we !== 1'b0 || busy !== 1'b0)
            $display("FAIL async_reset got=we%b busy%b exp=we0 busy0", fb_we, busy); else passed++;
        checks++; if (cursor_col !== 7'd0 || cursor_row !== 7'd0)
            $display("FAIL async_reset_cursor got=(%0d,%0d) exp=(0,0)", cursor_col, cursor_row); else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_write(2'd0, 8'h77, 1, acks, wes, wa, wd);
        checks++; if (acks !== 1 || wes !== 1 || wa !== 13'd0 || wd !== 8'h77 || busy !== 1'b0)
            $display("FAIL post_reset_char got=ack%0d we%0d %0d/%h exp=ack1 we1 0/77", acks, wes, wa, wd); else passed++;
        checks++; if (cursor_col !== 7'd1 || cursor_row !== 7'd0)
            $display("FAIL post_reset_cursor got=(%0d,%0d) exp=(1,0)", cursor_col, cursor_row); else passed++;
    endtask

    initial begin
        test_reset();
        test_char();
        test_cursor_regs();
        test_clear();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
